// File: rtl/iic_slave_pkg.sv
// Shared types and constants for the I2C target and its bus synchronizer.
package iic_slave_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_e;

    // Synchronized bus view: sampled SDA level plus single-cycle event strobes.
    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } bus_evt_t;

endpackage

// File: rtl/iic_bus_sync.sv
// Two-flop synchronizer, delay flop and edge/START/STOP detection for SCL and SDA.
module iic_bus_sync
    import iic_slave_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     scl,
    input  logic     sda,
    output bus_evt_t evt
);

    // [0],[1] synchronizer stages, [2] delay stage for edge detection
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;
    logic       scl_high_c;
    logic       sda_rise_c;
    logic       sda_fall_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sh <= '1;
            sda_sh <= '1;
        end else begin
            scl_sh <= {scl_sh[1:0], scl};
            sda_sh <= {sda_sh[1:0], sda};
        end
    end

    // SCL must be stable high across both compared samples to qualify START/STOP
    assign scl_high_c = scl_sh[1] & scl_sh[2];
    assign sda_rise_c = sda_sh[1] & ~sda_sh[2];
    assign sda_fall_c = ~sda_sh[1] & sda_sh[2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt.sda      <= 1'b1;
            evt.scl_rise <= 1'b0;
            evt.scl_fall <= 1'b0;
            evt.start    <= 1'b0;
            evt.stop     <= 1'b0;
        end else begin
            evt.sda      <= sda_sh[1];
            evt.scl_rise <= scl_sh[1] & ~scl_sh[2];
            evt.scl_fall <= ~scl_sh[1] & scl_sh[2];
            evt.start    <= sda_fall_c & scl_high_c;
            evt.stop     <= sda_rise_c & scl_high_c;
        end
    end

endmodule

// File: rtl/iic_slave.sv
// I2C target, 7-bit address, 8-bit data, open-drain SDA, no clock stretching.
module iic_slave
    import iic_slave_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int unsigned       HOLD_CYC   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SCL,
    inout  wire               SDA,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic              rw,
    output logic              busy,
    output logic              stop_det
);

    localparam int unsigned       HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  BIT_TOP = CNT_W'(DATA_W - 1);

    bus_evt_t           evt;
    state_e             state,     state_nxt;
    logic [DATA_W-1:0]  shift,     shift_nxt;
    logic [CNT_W-1:0]   bit_cnt,   bit_cnt_nxt;
    logic               byte_done, byte_done_nxt;
    logic               ack_seen,  ack_seen_nxt;
    logic [HOLD_W-1:0]  hold_cnt,  hold_cnt_nxt;
    logic               oe_pend,   oe_pend_nxt;
    logic               sda_oe,    sda_oe_nxt;
    logic [DATA_W-1:0]  rx_data_nxt;
    logic               rx_valid_nxt;
    logic               tx_req_nxt;
    logic               rw_nxt;
    logic               busy_nxt;
    logic               stop_det_nxt;

    iic_bus_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .scl  (SCL),
        .sda  (SDA),
        .evt  (evt)
    );

    // Open-drain: only ever pull low
    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift     <= '0;
            bit_cnt   <= BIT_TOP;
            byte_done <= 1'b0;
            ack_seen  <= 1'b0;
            hold_cnt  <= '0;
            oe_pend   <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_done <= byte_done_nxt;
            ack_seen  <= ack_seen_nxt;
            hold_cnt  <= hold_cnt_nxt;
            oe_pend   <= oe_pend_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            rw        <= rw_nxt;
            busy      <= busy_nxt;
            stop_det  <= stop_det_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        ack_seen_nxt  = ack_seen;
        hold_cnt_nxt  = hold_cnt;
        oe_pend_nxt   = oe_pend;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        rw_nxt        = rw;
        busy_nxt      = busy;
        stop_det_nxt  = 1'b0;

        // A scheduled SDA change takes effect once the hold delay after SCL fall expires
        if (hold_cnt != '0) begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
                sda_oe_nxt = oe_pend;
            end
        end

        if (evt.stop) begin
            state_nxt    = ST_IDLE;
            sda_oe_nxt   = 1'b0;
            hold_cnt_nxt = '0;
            stop_det_nxt = busy;
            busy_nxt     = 1'b0;
        end else if (evt.start) begin
            state_nxt     = ST_ADDR;
            sda_oe_nxt    = 1'b0;
            hold_cnt_nxt  = '0;
            bit_cnt_nxt   = BIT_TOP;
            byte_done_nxt = 1'b0;
            ack_seen_nxt  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (evt.scl_rise) begin
                        shift_nxt   = {shift[DATA_W-2:0], evt.sda};
                        bit_cnt_nxt = bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            byte_done_nxt = 1'b1;
                        end
                    end else if (evt.scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (shift[DATA_W-1:1] == SLAVE_ADDR) begin
                            state_nxt    = ST_ADDR_ACK;
                            busy_nxt     = 1'b1;
                            rw_nxt       = shift[0];
                            tx_req_nxt   = shift[0];
                            hold_cnt_nxt = HOLD_W'(HOLD_CYC);
                            oe_pend_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (evt.scl_fall) begin
                        bit_cnt_nxt   = BIT_TOP;
                        byte_done_nxt = 1'b0;
                        hold_cnt_nxt  = HOLD_W'(HOLD_CYC);
                        if (rw) begin
                            state_nxt   = ST_RD_DATA;
                            shift_nxt   = tx_data;
                            oe_pend_nxt = ~tx_data[DATA_W-1];
                        end else begin
                            state_nxt   = ST_WR_DATA;
                            oe_pend_nxt = 1'b0;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (evt.scl_rise) begin
                        shift_nxt   = {shift[DATA_W-2:0], evt.sda};
                        bit_cnt_nxt = bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            rx_data_nxt  = {shift[DATA_W-2:0], evt.sda};
                            rx_valid_nxt = 1'b1;
                            ack_seen_nxt = 1'b0;
                            state_nxt    = ST_WR_ACK;
                        end
                    end
                end

                // First fall schedules the ACK, second fall (end of 9th clock) releases it
                ST_WR_ACK: begin
                    if (evt.scl_fall) begin
                        hold_cnt_nxt = HOLD_W'(HOLD_CYC);
                        if (!ack_seen) begin
                            oe_pend_nxt  = 1'b1;
                            ack_seen_nxt = 1'b1;
                        end else begin
                            oe_pend_nxt   = 1'b0;
                            ack_seen_nxt  = 1'b0;
                            bit_cnt_nxt   = BIT_TOP;
                            byte_done_nxt = 1'b0;
                            state_nxt     = ST_WR_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (evt.scl_rise) begin
                        bit_cnt_nxt = bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            byte_done_nxt = 1'b1;
                        end
                    end else if (evt.scl_fall) begin
                        hold_cnt_nxt = HOLD_W'(HOLD_CYC);
                        if (byte_done) begin
                            byte_done_nxt = 1'b0;
                            ack_seen_nxt  = 1'b0;
                            oe_pend_nxt   = 1'b0;
                            state_nxt     = ST_RD_ACK;
                        end else begin
                            shift_nxt   = {shift[DATA_W-2:0], 1'b0};
                            oe_pend_nxt = ~shift[DATA_W-2];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (evt.scl_rise) begin
                        if (evt.sda == ACK) begin
                            tx_req_nxt   = 1'b1;
                            ack_seen_nxt = 1'b1;
                        end else begin
                            state_nxt    = ST_IDLE;
                            busy_nxt     = 1'b0;
                            sda_oe_nxt   = 1'b0;
                            hold_cnt_nxt = '0;
                        end
                    end else if (evt.scl_fall && ack_seen) begin
                        state_nxt     = ST_RD_DATA;
                        ack_seen_nxt  = 1'b0;
                        shift_nxt     = tx_data;
                        bit_cnt_nxt   = BIT_TOP;
                        byte_done_nxt = 1'b0;
                        hold_cnt_nxt  = HOLD_W'(HOLD_CYC);
                        oe_pend_nxt   = ~tx_data[DATA_W-1];
                    end
                end

                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_slave.sv
// Behavioural I2C master with pull-up driving iic_slave; checks against a transaction-level model.
module tb_iic_slave;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         Q          = 20;   // quarter SCL period in clk cycles

    logic       clk     = 1'b0;
    logic       rstn    = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    wire  [7:0] rx_data;
    wire        rx_valid, tx_req, rw, busy, stop_det;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    iic_slave #(.SLAVE_ADDR(SLAVE_ADDR), .HOLD_CYC(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .SCL      (scl),
        .SDA      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy),
        .stop_det (stop_det)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observers of user-side strobes and of the target pulling SDA
    logic [7:0] rx_q[$];
    logic [7:0] tx_src[$];
    int n_txreq = 0, n_stop = 0, n_overlap = 0, drv_cycles = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) begin
            n_txreq++;
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
            else tx_data = 8'h00;
        end
        if (stop_det) n_stop++;
        if (rx_valid && tx_req) n_overlap++;
        if (!m_low && sda === 1'b0) drv_cycles++;
    end

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; scl = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(Q); m_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); m_low = 1'b1;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_low = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); m_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(Q); m_low = ~b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2 * Q); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q); m_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); b = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    // Model: target ACKs only its own address; writes echo to rx, reads return tx bytes in order
    task automatic rand_xfer();
        logic [6:0] addr;
        logic       rd, ack, hit;
        logic [7:0] d[3];
        logic [7:0] got;
        int         n, stb, txb;
        addr = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLAVE_ADDR;
        rd   = 1'($urandom);
        n    = $urandom_range(1, 3);
        for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
        hit = (addr == SLAVE_ADDR);
        rx_q.delete();
        tx_src.delete();
        stb = n_stop;
        txb = n_txreq;
        if (rd) for (int i = 0; i < n; i++) tx_src.push_back(d[i]);
        bus_start();
        write_byte({addr, rd}, ack);
        check("rnd_addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (rd) begin
                    read_byte(i == n - 1, got);
                    check("rnd_rd_byte", 32'(got), 32'(d[i]));
                end else begin
                    write_byte(d[i], ack);
                    check("rnd_wr_ack", 32'(ack), 32'd0);
                end
            end
        end
        bus_stop();
        wait_clk(8);
        check("rnd_rx_cnt", rx_q.size(), (hit && !rd) ? n : 0);
        if (hit && !rd) for (int i = 0; i < n; i++) check("rnd_rx_data", 32'(rx_at(i)), 32'(d[i]));
        check("rnd_stop_det", n_stop - stb, (hit && !rd) ? 1 : 0);
        check("rnd_tx_req", n_txreq - txb, (hit && rd) ? n : 0);
        check("rnd_busy", 32'(busy), 32'd0);
        tx_src.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] got;
        int         stb, txb;

        wait_clk(5);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        rstn = 1'b1;
        wait_clk(5);

        // Two-byte write to our address
        rx_q.delete(); stb = n_stop;
        bus_start();
        write_byte(8'hA0, ack); check("t1_addr_ack", 32'(ack), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        write_byte(8'h3C, ack); check("t1_ack1", 32'(ack), 32'd0);
        write_byte(8'hC3, ack); check("t1_ack2", 32'(ack), 32'd0);
        bus_stop(); wait_clk(8);
        check("t1_rx_cnt", rx_q.size(), 2);
        check("t1_rx0", 32'(rx_at(0)), 32'h3C);
        check("t1_rx1", 32'(rx_at(1)), 32'hC3);
        check("t1_stop_det", n_stop - stb, 1);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Foreign address: target must stay off the bus
        rx_q.delete(); drv_cycles = 0;
        bus_start();
        write_byte(8'hA2, ack); check("t2_nack", 32'(ack), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        bus_stop(); wait_clk(8);
        check("t2_no_drive", drv_cycles, 0);
        check("t2_rx_cnt", rx_q.size(), 0);

        // Two-byte read, master NACKs the last one
        tx_src.delete(); tx_src.push_back(8'h5A); tx_src.push_back(8'hA5);
        txb = n_txreq;
        bus_start();
        write_byte(8'hA1, ack); check("t3_addr_ack", 32'(ack), 32'd0);
        check("t3_rw", 32'(rw), 32'd1);
        read_byte(1'b0, got); check("t3_byte0", 32'(got), 32'h5A);
        read_byte(1'b1, got); check("t3_byte1", 32'(got), 32'hA5);
        wait_clk(Q);
        check("t3_sda_rel", 32'(sda), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        bus_stop(); wait_clk(8);
        check("t3_tx_req", n_txreq - txb, 2);

        // Write, repeated START, one-byte read
        rx_q.delete(); tx_src.delete(); tx_src.push_back(8'h96);
        stb = n_stop; txb = n_txreq;
        bus_start();
        write_byte(8'hA0, ack); check("t4_addr_w", 32'(ack), 32'd0);
        write_byte(8'h11, ack); check("t4_ack", 32'(ack), 32'd0);
        bus_rstart();
        write_byte(8'hA1, ack); check("t4_addr_r", 32'(ack), 32'd0);
        read_byte(1'b1, got); check("t4_rd", 32'(got), 32'h96);
        check("t4_rw", 32'(rw), 32'd1);
        bus_stop(); wait_clk(8);
        check("t4_rx_cnt", rx_q.size(), 1);
        check("t4_rx0", 32'(rx_at(0)), 32'h11);
        check("t4_tx_req", n_txreq - txb, 1);
        check("t4_no_stop", n_stop - stb, 0);

        // STOP half way through a data byte
        rx_q.delete(); stb = n_stop;
        bus_start();
        write_byte(8'hA0, ack); check("t5_addr_ack", 32'(ack), 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop(); wait_clk(8);
        check("t5_rx_cnt", rx_q.size(), 0);
        check("t5_stop_det", n_stop - stb, 1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sda", 32'(sda), 32'd1);

        // Reset while the target holds the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'((8'hA0 >> i) & 8'h01));
        wait_clk(Q); m_low = 1'b0; wait_clk(Q);
        check("t6_ack_drive", 32'(sda), 32'd0);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_sda_rel", 32'(sda), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rx_data", 32'(rx_data), 32'd0);
        check("t6_rw", 32'(rw), 32'd0);
        check("t6_strobes", {29'd0, rx_valid, tx_req, stop_det}, 32'd0);
        wait_clk(4); rstn = 1'b1; wait_clk(4);
        scl = 1'b1; wait_clk(Q);
        rx_q.delete(); stb = n_stop;
        bus_start();
        write_byte(8'hA0, ack); check("t6_resume_ack", 32'(ack), 32'd0);
        write_byte(8'h77, ack); check("t6_resume_ack1", 32'(ack), 32'd0);
        bus_stop(); wait_clk(8);
        check("t6_rx0", 32'(rx_at(0)), 32'h77);
        check("t6_stop_det", n_stop - stb, 1);

        for (int k = 0; k < 6; k++) rand_xfer();

        check("no_overlap", n_overlap, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
